cla_seq128: RTL and testbench
=============================

CLA_SEQ128 -- requirements
Module: cla_seq128

Interface
REQ-001 Parameter: n, default 128, total operand width.
REQ-002 Parameter: m, default 32, slice width; n SHALL be an integer multiple of m; beats = n/m (default 4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_valid  input  1  requester presents operands.
REQ-006 start_ready  output  1  block accepts operands this cycle.
REQ-007 cin  input  1  carry-in, sampled at acceptance only.
REQ-008 a  input  n  operand A, sampled at acceptance only.
REQ-009 b  input  n  operand B, sampled at acceptance only.
REQ-010 s  output  n  registered sum.
REQ-011 cout  output  1  registered carry-out.
REQ-012 gen  output  1  registered group generate of the full n-bit add.
REQ-013 prop  output  1  registered group propagate of the full n-bit add.
REQ-014 done_valid  output  1  result valid.
REQ-015 done_ready  input  1  consumer accepts result.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 Datapath: exactly one m-bit carry-lookahead slice adder (cin,a,b -> s,gen,prop,cout), reused for every beat; no n-bit adder.
REQ-018 FSM states: IDLE, RUN, DONE; start_ready = (state==IDLE); done_valid = (state==DONE).
REQ-019 IDLE: start_valid=1 -> capture a, b, cin; clear beat counter, gen_acc=0, prop_acc=1; go RUN.
REQ-020 RUN, beat k (0..beats-1): slice adds a[k*m+:m], b[k*m+:m], carry_reg (cin for k=0); result written to s[k*m+:m]; carry_reg <= slice cout.
REQ-021 RUN accumulation per beat: gen_acc <= slice_gen | (slice_prop & gen_acc); prop_acc <= prop_acc & slice_prop.
REQ-022 After beat beats-1: cout, gen, prop take final carry_reg, gen_acc, prop_acc; go DONE.
REQ-023 Latency: acceptance in cycle C0 -> RUN in C1..C4 -> done_valid high from C5 (default params); latency = beats+1 cycles.
REQ-024 DONE: s, cout, gen, prop held stable; done_ready=1 -> IDLE next cycle; otherwise stay DONE indefinitely.
REQ-025 Invariant at DONE: cout == gen | (prop & captured cin); {cout,s} == a + b + cin (mod 2^(n+1)).
REQ-026 start_valid outside IDLE ignored; changes on a, b, cin after acceptance have no effect.
REQ-027 No overlap: new acceptance possible at earliest in the cycle after the done handshake; max throughput 1 op per beats+2 cycles.
REQ-028 s, cout, gen, prop retain last result in IDLE until next acceptance, then update beat-wise; never read outside DONE.
REQ-029 done_ready while not DONE has no effect.

Reset
REQ-030 rst=1 at rising edge -> state IDLE; s=0, cout=0, gen=0, prop=0, done_valid=0, busy=0, start_ready=1 from next cycle.
REQ-031 rst dominates all other inputs, including mid-RUN and in DONE; the in-flight operation is discarded, no done_valid.
REQ-032 start_valid in the cycle rst is high is not accepted.

Verification
REQ-033 a=all-ones, b=0, cin=1 -> s=0, cout=1, gen=0, prop=1, done_valid at C5.
REQ-034 a=all-ones, b=1, cin=0 -> s=0, cout=1, gen=1, prop=0.
REQ-035 a=0x0000_0000_FFFF_FFFF (low 32 set), b=1, cin=0 -> s=0x1_0000_0000, cout=0, gen=0, prop=0 (carry crosses slice boundary).
REQ-036 Hold done_ready=0 for 10 cycles in DONE with start_valid=1 and changing a/b -> outputs stable, start_ready=0, no new acceptance.
REQ-037 Assert rst in C2 of an operation -> IDLE next cycle, outputs zero, no done_valid; subsequent op 5+7 cin=0 -> s=12, cout=0.
REQ-038 1000 random back-to-back ops with random done_ready stalls -> every result matches a+b+cin and REQ-025 invariant.

Source files
------------

// File: rtl/cla_seq128.sv
// Sequential n-bit adder: a single m-bit carry-lookahead slice is reused over n/m beats,
// accumulating group generate/propagate, with valid/ready handshakes on both sides.
module cla_seq128 #(
    parameter int unsigned n = 128,
    parameter int unsigned m = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         gen,
    output logic         prop,
    output logic         done_valid,
    input  logic         done_ready,
    output logic         busy
);
    localparam int unsigned BEATS = n / m;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_accept;
    logic          w_last;

    logic [n-1:0]  r_a;
    logic [n-1:0]  r_b;
    logic          r_carry;
    logic [CW-1:0] r_beat;
    logic          r_gacc;
    logic          r_pacc;
    logic [n-1:0]  r_s;
    logic          r_cout;
    logic          r_gen;
    logic          r_prop;

    logic [m-1:0]  w_sa;
    logic [m-1:0]  w_sb;
    logic [m-1:0]  w_g;
    logic [m-1:0]  w_p;
    logic [m-1:0]  w_pg;
    logic [m-1:0]  w_pp;
    logic [m:0]    w_c;
    logic [m-1:0]  w_sum;
    logic          w_sgen;
    logic          w_sprop;
    logic          w_scout;

    // Operand registers shift down one slice per beat, so the slice always sees the low m bits.
    assign w_sa   = r_a[m-1:0];
    assign w_sb   = r_b[m-1:0];
    assign w_last = (r_beat == CW'(BEATS - 1));

    // Slice adder: prefix (generate, propagate) over bits 0..i gives every carry directly from carry-in.
    always_comb begin
        w_g   = w_sa & w_sb;
        w_p   = w_sa ^ w_sb;
        w_pg  = '0;
        w_pp  = '0;
        w_pg[0] = w_g[0];
        w_pp[0] = w_p[0];
        for (int i = 1; i < int'(m); i++) begin
            w_pg[i] = w_g[i] | (w_p[i] & w_pg[i-1]);
            w_pp[i] = w_p[i] & w_pp[i-1];
        end
        w_c    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < int'(m); i++) begin
            w_c[i+1] = w_pg[i] | (w_pp[i] & r_carry);
        end
        w_sum   = w_p ^ w_c[m-1:0];
        w_sgen  = w_pg[m-1];
        w_sprop = w_pp[m-1];
        w_scout = w_c[m];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (done_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on acceptance, one slice per RUN cycle, publish flags on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_beat  <= '0;
            r_gacc  <= 1'b0;
            r_pacc  <= 1'b1;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_gen   <= 1'b0;
            r_prop  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_beat  <= '0;
            r_gacc  <= 1'b0;
            r_pacc  <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> m;
            r_b     <= r_b >> m;
            r_carry <= w_scout;
            r_gacc  <= w_sgen | (w_sprop & r_gacc);
            r_pacc  <= r_pacc & w_sprop;
            r_beat  <= r_beat + CW'(1);
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (r_beat == CW'(k)) r_s[k*m +: m] <= w_sum;
            end
            if (w_last) begin
                r_cout <= w_scout;
                r_gen  <= w_sgen | (w_sprop & r_gacc);
                r_prop <= r_pacc & w_sprop;
            end
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign done_valid  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign s           = r_s;
    assign cout        = r_cout;
    assign gen         = r_gen;
    assign prop        = r_prop;

endmodule

// File: tb/tb_cla_seq128.sv
// Self-checking bench for cla_seq128: directed corner vectors, stall/hold, mid-op reset and
// randomized back-to-back operations checked against an arithmetic reference model.
module tb_cla_seq128;
    localparam int unsigned N = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         cout;
    logic         gen;
    logic         prop;
    logic         done_valid;
    logic         done_ready;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cla_seq128 dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .cin        (cin),
        .a          (a),
        .b          (b),
        .s          (s),
        .cout       (cout),
        .gen        (gen),
        .prop       (prop),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .busy       (busy)
    );

    // Reference: {cout, gen, prop, s} from plain wide arithmetic.
    function automatic logic [N+2:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mc);
        logic [N:0] full;
        logic [N:0] nocin;
        full  = {1'b0, ma} + {1'b0, mb} + (N+1)'(mc);
        nocin = {1'b0, ma} + {1'b0, mb};
        return {full[N], nocin[N], (nocin == {1'b0, {N{1'b1}}}), full[N-1:0]};
    endfunction

    function automatic logic [N-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offers one operation at the current negedge; returns at the negedge where done_valid is seen.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                          output logic [N+2:0] obs, output int lat, output logic rdy);
        a = ta; b = tb; cin = tc; start_valid = 1'b1;
        rdy = start_ready;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start_valid = 1'b0;
                a = rnd128(); b = rnd128(); cin = 1'($urandom());
            end
            if (done_valid) begin
                lat = i;
                break;
            end
        end
        obs = {cout, gen, prop, s};
    endtask

    task automatic finish_op(input int stall);
        repeat (stall) @(negedge clk);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_valid = 1'b1; done_ready = 1'b0;
        a = rnd128(); b = rnd128(); cin = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({start_ready, busy, done_valid, cout, gen, prop, s} !== {3'b100, 3'b000, {N{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b busy=%b dv=%b cout=%b gen=%b prop=%b s=%h, required 1 0 0 0 0 0 0",
                     start_ready, busy, done_valid, cout, gen, prop, s);
        end
        rst = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({start_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_no_accept: rdy=%b busy=%b, required 1 0", start_ready, busy);
        end
    endtask

    task automatic test_vectors();
        logic [N-1:0] va[3];
        logic [N-1:0] vb[3];
        logic         vc[3];
        logic [N+2:0] ve[3];
        logic [N+2:0] obs;
        logic [N-1:0] lo;
        int           lat;
        logic         rdy;
        lo = 128'h0000_0000_FFFF_FFFF;
        va[0] = {N{1'b1}}; vb[0] = '0;         vc[0] = 1'b1; ve[0] = {3'b101, {N{1'b0}}};
        va[1] = {N{1'b1}}; vb[1] = N'(1);      vc[1] = 1'b0; ve[1] = {3'b110, {N{1'b0}}};
        va[2] = lo;        vb[2] = N'(1);      vc[2] = 1'b0; ve[2] = {3'b000, N'(128'h1_0000_0000)};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], obs, lat, rdy);
            n_tests++;
            if (obs !== ve[i]) begin
                n_fail++;
                $display("FAIL vector%0d_result: got cout/gen/prop=%b s=%h, required %b s=%h",
                         i, obs[N+2:N], obs[N-1:0], ve[i][N+2:N], ve[i][N-1:0]);
            end
            n_tests++;
            if (lat !== 5 || rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL vector%0d_latency: got lat=%0d rdy=%b, required 5 1", i, lat, rdy);
            end
            finish_op(0);
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] ta;
        logic [N-1:0] tb;
        logic [N+2:0] exp;
        logic [N+2:0] obs;
        int           lat;
        logic         rdy;
        int           bad;
        ta = rnd128(); tb = rnd128();
        exp = model(ta, tb, 1'b1);
        run_op(ta, tb, 1'b1, obs, lat, rdy);
        n_tests++;
        if (obs !== exp || lat !== 5) begin
            n_fail++;
            $display("FAIL hold_result: got %h lat=%0d, required %h lat=5", obs, lat, exp);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start_valid = 1'b1; a = rnd128(); b = rnd128(); cin = 1'($urandom());
            @(negedge clk);
            if ({done_valid, start_ready, busy, cout, gen, prop, s} !== {3'b101, exp}) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d of 10 stalled cycles changed, required 0", bad);
        end
        start_valid = 1'b0;
        finish_op(0);
        n_tests++;
        if ({start_ready, busy, done_valid, cout, gen, prop, s} !== {3'b100, exp}) begin
            n_fail++;
            $display("FAIL hold_release: rdy=%b busy=%b dv=%b s=%h, required 1 0 0 s=%h",
                     start_ready, busy, done_valid, s, exp[N-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [N+2:0] obs;
        int           lat;
        logic         rdy;
        int           seen;
        a = rnd128(); b = rnd128(); cin = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({start_ready, busy, done_valid, cout, gen, prop, s} !== {3'b100, 3'b000, {N{1'b0}}}) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b busy=%b dv=%b s=%h, required 1 0 0 s=0",
                     start_ready, busy, done_valid, s);
        end
        rst = 1'b0; start_valid = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_valid || busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrun_discard: %0d cycles busy/done after reset, required 0", seen);
        end
        run_op(N'(5), N'(7), 1'b0, obs, lat, rdy);
        n_tests++;
        if (obs !== {3'b000, N'(12)} || lat !== 5) begin
            n_fail++;
            $display("FAIL after_reset_op: got %h lat=%0d, required s=12 cout=0 lat=5", obs, lat);
        end
        finish_op(1);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ta;
        logic [N-1:0] tb;
        logic         tc;
        logic [N+2:0] exp;
        logic [N+2:0] obs;
        int           lat;
        logic         rdy;
        int           bad_res;
        int           bad_inv;
        int           bad_tim;
        bad_res = 0; bad_inv = 0; bad_tim = 0;
        for (int i = 0; i < 1000; i++) begin
            ta = rnd128();
            tc = 1'($urandom());
            case ($urandom_range(0, 3))
                0:       tb = ~ta;
                1:       begin ta = {N{1'b1}}; tb = N'($urandom_range(0, 3)); end
                2:       begin tb = rnd128(); ta[63:0] = ~tb[63:0]; end
                default: tb = rnd128();
            endcase
            exp = model(ta, tb, tc);
            run_op(ta, tb, tc, obs, lat, rdy);
            if (obs !== exp) begin
                bad_res++;
                if (bad_res <= 3)
                    $display("FAIL b2b_result op%0d: got %h, required %h", i, obs, exp);
            end
            if (obs[N+2] !== (obs[N+1] | (obs[N] & tc))) bad_inv++;
            if (lat !== 5 || rdy !== 1'b1) bad_tim++;
            finish_op(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
        end
        n_tests++;
        if (bad_res != 0) begin
            n_fail++;
            $display("FAIL b2b_results: %0d wrong of 1000, required 0", bad_res);
        end
        n_tests++;
        if (bad_inv != 0) begin
            n_fail++;
            $display("FAIL b2b_invariant: %0d ops with cout != gen|(prop&cin), required 0", bad_inv);
        end
        n_tests++;
        if (bad_tim != 0) begin
            n_fail++;
            $display("FAIL b2b_timing: %0d ops with bad latency/ready, required 0", bad_tim);
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
